// File: rtl/dmem_arbiter.sv
// Two-port data memory arbiter: pipeline has priority, the debug/loader port is
// granted after STARVE_MAX consecutive pipeline wins; one single-cycle access per clock.
module dmem_arbiter #(
  parameter int unsigned ADDR_LIMIT = 64,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p_req,
  input  logic        p_we,
  input  logic [63:0] p_addr,
  input  logic [63:0] p_wdata,
  output logic        p_gnt,
  output logic        p_rvalid,
  output logic        p_err,
  output logic [63:0] p_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic        d_err,
  output logic [63:0] d_rdata,
  output logic [63:0] Mem_Addr,
  output logic [63:0] Write_DataMEM,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [63:0] Read_Data,
  output logic        pipe_stall
);

  // state  | meaning
  // IDLE   | no access this cycle
  // BUSY_P | pipeline access on the memory bus
  // BUSY_D | debug/loader access on the memory bus
  typedef enum logic [1:0] {IDLE, BUSY_P, BUSY_D} state_t;

  localparam logic [63:0] LAST_OK    = 64'(ADDR_LIMIT) - 64'd8;
  localparam logic [2:0]  STARVE_LIM = 3'(STARVE_MAX);

  state_t      state, state_nxt;
  logic [2:0]  starve_cnt;
  logic        p_wins, d_wins;
  logic        busy, oob;
  logic        lat_we;
  logic [63:0] lat_addr, lat_wdata;
  logic        p_load_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Every state re-arbitrates each edge, so BUSY states chain without idle cycles.
  always_comb begin
    d_wins    = d_req & (~p_req | (starve_cnt == STARVE_LIM));
    p_wins    = p_req & ~d_wins;
    state_nxt = IDLE;
    if (p_wins)      state_nxt = BUSY_P;
    else if (d_wins) state_nxt = BUSY_D;
  end

  always_comb begin
    p_gnt         = (state == BUSY_P);
    d_gnt         = (state == BUSY_D);
    busy          = p_gnt | d_gnt;
    oob           = busy & (lat_addr > LAST_OK);
    Mem_Addr      = busy ? lat_addr  : 64'd0;
    Write_DataMEM = busy ? lat_wdata : 64'd0;
    MemRead       = busy & ~lat_we & ~oob;
    MemWrite      = busy &  lat_we & ~oob;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= 3'd0;
    end else if (!d_req || d_wins) begin
      starve_cnt <= 3'd0;
    end else if (p_wins && starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_we    <= 1'b0;
      lat_addr  <= 64'd0;
      lat_wdata <= 64'd0;
    end else if (p_wins) begin
      lat_we    <= p_we;
      lat_addr  <= p_addr;
      lat_wdata <= p_wdata;
    end else if (d_wins) begin
      lat_we    <= d_we;
      lat_addr  <= d_addr;
      lat_wdata <= d_wdata;
    end
  end

  // Completion registers; out-of-range accesses return zero data with err set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_rvalid    <= 1'b0;
      p_err       <= 1'b0;
      p_rdata     <= 64'd0;
      d_rvalid    <= 1'b0;
      d_err       <= 1'b0;
      d_rdata     <= 64'd0;
      p_load_done <= 1'b0;
    end else begin
      p_rvalid    <= p_gnt;
      p_err       <= p_gnt & oob;
      d_rvalid    <= d_gnt;
      d_err       <= d_gnt & oob;
      p_load_done <= p_gnt & ~lat_we;
      if (p_gnt) begin
        if (oob)          p_rdata <= 64'd0;
        else if (!lat_we) p_rdata <= Read_Data;
      end
      if (d_gnt) begin
        if (oob)          d_rdata <= 64'd0;
        else if (!lat_we) d_rdata <= Read_Data;
      end
    end
  end

  assign pipe_stall = (p_req & ~p_gnt) | p_load_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a cycle-level reference
// model built from the arbitration rules, with its own copy of memory contents.
module tb_dmem_arbiter;
  localparam int ADDR_LIMIT = 64;
  localparam int STARVE_MAX = 4;

  logic        clk, reset_n;
  logic        p_req, p_we, d_req, d_we;
  logic [63:0] p_addr, p_wdata, d_addr, d_wdata;
  logic        p_gnt, p_rvalid, p_err, d_gnt, d_rvalid, d_err;
  logic [63:0] p_rdata, d_rdata;
  logic [63:0] Mem_Addr, Write_DataMEM, Read_Data;
  logic        MemWrite, MemRead, pipe_stall;

  dmem_arbiter #(.ADDR_LIMIT(ADDR_LIMIT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_err(p_err), .p_rdata(p_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .d_rdata(d_rdata),
    .Mem_Addr(Mem_Addr), .Write_DataMEM(Write_DataMEM),
    .MemWrite(MemWrite), .MemRead(MemRead),
    .Read_Data(Read_Data), .pipe_stall(pipe_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical memory seen by the DUT.
  logic [7:0] phys_mem [ADDR_LIMIT];
  logic       mem_clear;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < ADDR_LIMIT; i++) phys_mem[i] <= 8'hFF;
      phys_mem[8] <= 8'hF4;
      for (int i = 9; i < 16; i++) phys_mem[i] <= 8'h00;
    end else if (MemWrite) begin
      for (int i = 0; i < 8; i++)
        phys_mem[(int'(Mem_Addr[5:0]) + i) % ADDR_LIMIT] <= Write_DataMEM[8*i +: 8];
    end
  end

  always_comb begin
    Read_Data = '0;
    for (int i = 0; i < 8; i++)
      Read_Data[8*i +: 8] = phys_mem[(int'(Mem_Addr[5:0]) + i) % ADDR_LIMIT];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: its own memory image plus the access currently on the bus.
  logic [7:0]  ref_mem [ADDR_LIMIT];
  int          m_starve;
  int          m_gnt;          // 0 none, 1 pipeline, 2 debug
  logic        m_we;
  logic [63:0] m_addr, m_wdata;
  logic        m_p_rv, m_d_rv, m_p_err, m_d_err, m_p_ld;
  logic [63:0] m_prdata, m_drdata;

  function automatic logic [63:0] ref_read(input logic [63:0] a);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_mem[(int'(a[5:0]) + i) % ADDR_LIMIT];
    return v;
  endfunction

  function automatic logic out_of_range(input logic [63:0] a);
    return a > 64'(ADDR_LIMIT - 8);
  endfunction

  task automatic model_reset();
    m_starve = 0; m_gnt = 0; m_we = 0; m_addr = '0; m_wdata = '0;
    m_p_rv = 0; m_d_rv = 0; m_p_err = 0; m_d_err = 0; m_p_ld = 0;
    m_prdata = '0; m_drdata = '0;
  endtask

  task automatic model_edge();
    logic bad, dw, pw;
    logic [63:0] rd;
    m_p_rv = 0; m_d_rv = 0; m_p_err = 0; m_d_err = 0; m_p_ld = 0;
    if (m_gnt != 0) begin
      bad = out_of_range(m_addr);
      rd  = ref_read(m_addr);
      if (!bad && m_we)
        for (int i = 0; i < 8; i++) ref_mem[(int'(m_addr[5:0]) + i) % ADDR_LIMIT] = m_wdata[8*i +: 8];
      if (m_gnt == 1) begin
        m_p_rv = 1; m_p_err = bad; m_p_ld = !m_we;
        if (bad) m_prdata = '0; else if (!m_we) m_prdata = rd;
      end else begin
        m_d_rv = 1; m_d_err = bad;
        if (bad) m_drdata = '0; else if (!m_we) m_drdata = rd;
      end
    end
    dw = d_req && (!p_req || m_starve == STARVE_MAX);
    pw = p_req && !dw;
    if (!d_req || dw) m_starve = 0;
    else if (pw && m_starve < STARVE_MAX) m_starve++;
    if (pw)      begin m_gnt = 1; m_we = p_we; m_addr = p_addr; m_wdata = p_wdata; end
    else if (dw) begin m_gnt = 2; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; end
    else         m_gnt = 0;
  endtask

  task automatic check_outputs();
    logic busy, bad;
    busy = (m_gnt != 0);
    bad  = busy && out_of_range(m_addr);
    chk("p_gnt", p_gnt, m_gnt == 1);
    chk("d_gnt", d_gnt, m_gnt == 2);
    chk("p_rvalid", p_rvalid, m_p_rv);
    chk("d_rvalid", d_rvalid, m_d_rv);
    chk("p_err", p_err, m_p_err);
    chk("d_err", d_err, m_d_err);
    chk("p_rdata", p_rdata, m_prdata);
    chk("d_rdata", d_rdata, m_drdata);
    chk("mem_addr", Mem_Addr, busy ? m_addr : 64'd0);
    chk("mem_wdata", Write_DataMEM, busy ? m_wdata : 64'd0);
    chk("mem_read", MemRead, busy && !m_we && !bad);
    chk("mem_write", MemWrite, busy && m_we && !bad);
    chk("pipe_stall", pipe_stall, (p_req && m_gnt != 1) || m_p_ld);
    chk("both_gnt", p_gnt & d_gnt, 1'b0);
    chk("rd_and_wr", MemRead & MemWrite, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, {62'd0, p_gnt, d_gnt}, 64'd0);
    chk({tag, "_rvalid"}, {62'd0, p_rvalid, d_rvalid}, 64'd0);
    chk({tag, "_err"}, {62'd0, p_err, d_err}, 64'd0);
    chk({tag, "_p_rdata"}, p_rdata, 64'd0);
    chk({tag, "_d_rdata"}, d_rdata, 64'd0);
    chk({tag, "_mem_addr"}, Mem_Addr, 64'd0);
    chk({tag, "_mem_wdata"}, Write_DataMEM, 64'd0);
    chk({tag, "_mem_rw"}, {62'd0, MemRead, MemWrite}, 64'd0);
  endtask

  // One complete access on a port; returns data/err seen in the completion cycle
  // and the memory strobe/address seen during the grant cycle.
  task automatic access(input bit on_d, input logic we, input logic [63:0] addr,
                        input logic [63:0] wdata, output logic [63:0] rdata,
                        output logic err, output logic mread, output logic [63:0] maddr);
    logic granted;
    granted = 0;
    if (on_d) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; end
    else      begin p_req = 1; p_we = we; p_addr = addr; p_wdata = wdata; end
    for (int n = 0; n < 20 && !granted; n++) begin
      step();
      granted = on_d ? d_gnt : p_gnt;
    end
    chk("grant_seen", granted, 1'b1);
    mread = MemRead;
    maddr = Mem_Addr;
    if (on_d) d_req = 0; else p_req = 0;
    step();
    chk("rvalid_lat", on_d ? d_rvalid : p_rvalid, 1'b1);
    rdata = on_d ? d_rdata : p_rdata;
    err   = on_d ? d_err : p_err;
  endtask

  task automatic rand_port(input bit on_d);
    logic       req, gnt;
    logic       we;
    logic [63:0] a, w;
    req = on_d ? d_req : p_req;
    gnt = on_d ? d_gnt : p_gnt;
    we  = 1'($urandom_range(0, 1));
    a   = 64'($urandom_range(0, ADDR_LIMIT - 1));
    w   = {$urandom, $urandom};
    if (!req || gnt) begin
      if ($urandom_range(0, 9) < 6) begin
        if (on_d) begin d_req = 1; d_we = we; d_addr = a; d_wdata = w; end
        else      begin p_req = 1; p_we = we; p_addr = a; p_wdata = w; end
      end else begin
        if (on_d) d_req = 0; else p_req = 0;
      end
    end else if ($urandom_range(0, 19) == 0) begin
      if (on_d) d_req = 0; else p_req = 0;
    end
  endtask

  initial begin
    logic [63:0] rd, ma;
    logic        er, mr;
    logic [9:0]  seq;

    reset_n = 0; mem_clear = 1;
    p_req = 0; p_we = 0; p_addr = '0; p_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < ADDR_LIMIT; i++) ref_mem[i] = 8'hFF;
    ref_mem[8] = 8'hF4;
    for (int i = 9; i < 16; i++) ref_mem[i] = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    chk("reset_stall", pipe_stall, 1'b0);
    mem_clear = 0;
    reset_n = 1;

    // Pipeline load of byte 8.
    access(0, 0, 64'd8, 64'd0, rd, er, mr, ma);
    chk("p_load_mread", mr, 1'b1);
    chk("p_load_maddr", ma, 64'd8);
    chk("p_load_data", rd, 64'h0000_0000_0000_00F4);
    chk("p_load_err", er, 1'b0);

    // Debug store then pipeline load of the same location.
    access(1, 1, 64'd16, 64'h1122_3344_5566_7788, rd, er, mr, ma);
    chk("d_store_err", er, 1'b0);
    step();
    chk("d_rvalid_once", d_rvalid, 1'b0);
    access(0, 0, 64'd16, 64'd0, rd, er, mr, ma);
    chk("p_after_d_store", rd, 64'h1122_3344_5566_7788);

    // Bounds.
    access(0, 0, 64'd57, 64'd0, rd, er, mr, ma);
    chk("oob_mread", mr, 1'b0);
    chk("oob_err", er, 1'b1);
    chk("oob_rdata", rd, 64'd0);
    access(0, 0, 64'd56, 64'd0, rd, er, mr, ma);
    chk("edge_err", er, 1'b0);
    chk("edge_rdata", rd, 64'hFFFF_FFFF_FFFF_FFFF);

    // Contention: both held continuously.
    step();
    p_req = 1; p_we = 0; p_addr = 64'd24;
    d_req = 1; d_we = 0; d_addr = 64'd32;
    for (int i = 0; i < 10; i++) begin
      step();
      seq[i] = d_gnt;
      chk("contend_onehot", p_gnt ^ d_gnt, 1'b1);
    end
    chk("contend_seq", seq, 10'b10_0001_0000);
    p_req = 0; d_req = 0;
    repeat (2) step();

    // One-cycle debug pulse while the pipeline holds the bus.
    p_req = 1; p_we = 0; p_addr = 64'd0;
    step();
    d_req = 1; d_we = 1; d_addr = 64'd40; d_wdata = 64'h5;
    step();
    d_req = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("withdrawn_d_gnt", d_gnt, 1'b0);
      chk("withdrawn_stall", pipe_stall, !p_gnt || p_rvalid);
    end
    p_req = 0;
    repeat (2) step();

    // Reset during a debug write.
    d_req = 1; d_we = 1; d_addr = 64'd0; d_wdata = 64'hAA;
    begin
      logic granted;
      granted = 0;
      for (int n = 0; n < 20 && !granted; n++) begin
        step();
        granted = d_gnt;
      end
      chk("rst_write_grant", granted, 1'b1);
    end
    chk("mw_before_rst", MemWrite, 1'b1);
    reset_n = 0;
    #1;
    check_all_zero("rst_mid");
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("rst_mem0", {56'd0, phys_mem[0]}, 64'hFF);
    check_all_zero("rst_hold");
    reset_n = 1;

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      step();
      rand_port(0);
      rand_port(1);
    end
    p_req = 0; d_req = 0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
